// File: rtl/fadd_align_if.sv
// Operand and result bundles of the binary32 adder front end.
// The slave side belongs to fadd_align; the master side to its producer/consumer.
interface fadd_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [1:0]  rm_in;

  logic        out_valid;
  logic        out_ready;
  logic [1:0]  rm;
  logic        is_nan;
  logic        is_inf;
  logic [22:0] inf_nan_frac;
  logic        sign;
  logic [7:0]  temp_exp;
  logic [27:0] cal_frac;

  modport slave (
    input  in_valid, a, b, sub, rm_in, out_ready,
    output in_ready, out_valid, rm, is_nan, is_inf, inf_nan_frac, sign, temp_exp, cal_frac
  );

  modport master (
    output in_valid, a, b, sub, rm_in, out_ready,
    input  in_ready, out_valid, rm, is_nan, is_inf, inf_nan_frac, sign, temp_exp, cal_frac
  );
endinterface

// File: rtl/fadd_align.sv
// Unpack, classify, swap, align and add/subtract front end of the binary32 adder (2-stage valid/ready).
// Define FADD_ALIGN_SUB_EN to honour the sub input; otherwise the block is add-only.
module fadd_align (
  input  logic        clk,
  input  logic        rst,
  fadd_align_if.slave bus
);

  typedef struct packed {
    logic [26:0] large27;
    logic [26:0] small27;
    logic [7:0]  exp_l;
    logic        sign_l;
    logic        op_sub;
    logic [1:0]  rm;
    logic        is_nan;
    logic        is_inf;
  } s1_t;

  typedef struct packed {
    logic [27:0] cal_frac;
    logic [7:0]  temp_exp;
    logic        sign;
    logic [1:0]  rm;
    logic        is_nan;
    logic        is_inf;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d, s1_calc;
  s2_t  s2_q, s2_d, s2_calc;
  logic s2_load;
  logic in_ready;

  logic sub_eff;
`ifdef FADD_ALIGN_SUB_EN
  assign sub_eff = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign sub_eff    = 1'b0;
`endif

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic [7:0]  exp_a, exp_b, exp_l, exp_s;
  logic [22:0] frac_a, frac_b, frac_l, frac_s;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        eb_sign, op_sub, swap, sign_l;
  logic [23:0] large24, small24;
  logic [7:0]  shift;
  logic [26:0] small_ext, small_shr, lost_mask, small27;

  assign exp_a  = bus.a[30:23];
  assign exp_b  = bus.b[30:23];
  assign frac_a = bus.a[22:0];
  assign frac_b = bus.b[22:0];

  assign a_nan = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign b_nan = (exp_b == 8'hFF) && (frac_b != 23'd0);
  assign a_inf = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign b_inf = (exp_b == 8'hFF) && (frac_b == 23'd0);

  assign eb_sign = bus.b[31] ^ sub_eff;
  assign op_sub  = bus.a[31] ^ eb_sign;
  assign swap    = bus.a[30:0] < bus.b[30:0];

  assign exp_l  = swap ? exp_b : exp_a;
  assign exp_s  = swap ? exp_a : exp_b;
  assign frac_l = swap ? frac_b : frac_a;
  assign frac_s = swap ? frac_a : frac_b;
  assign sign_l = swap ? eb_sign : bus.a[31];

  assign large24 = {|exp_l, frac_l};
  assign small24 = {|exp_s, frac_s};

  // A denormal behaves as exponent 1, hence the extra -1 against a normal operand.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    shift = exp_l - exp_s;
    if (exp_l != 8'd0 && exp_s == 8'd0) shift = shift - 8'd1;
  end

  assign small_ext = {small24, 3'b000};
  assign small_shr = small_ext >> shift;
  assign lost_mask = (27'd1 << shift) - 27'd1;

  always_comb begin
    small27 = small_shr | {26'd0, |(small_ext & lost_mask)};
    if (shift >= 8'd26) small27 = {26'd0, |small24};
  end

  always_comb begin
    s1_calc         = '0;
    s1_calc.large27 = {large24, 3'b000};
    s1_calc.small27 = small27;
    s1_calc.exp_l   = exp_l;
    s1_calc.sign_l  = sign_l;
    s1_calc.op_sub  = op_sub;
    s1_calc.rm      = bus.rm_in;
    s1_calc.is_nan  = a_nan | b_nan | (a_inf & b_inf & op_sub);
    s1_calc.is_inf  = a_inf | b_inf;
  end

  // ---------------- stage 2: add/subtract and sign ----------------
  logic [27:0] sum;

  assign sum = s1_q.op_sub ? ({1'b0, s1_q.large27} - {1'b0, s1_q.small27})
                           : ({1'b0, s1_q.large27} + {1'b0, s1_q.small27});

  always_comb begin
    s2_calc          = '0;
    s2_calc.cal_frac = sum;
    s2_calc.temp_exp = s1_q.exp_l;
    s2_calc.rm       = s1_q.rm;
    s2_calc.is_nan   = s1_q.is_nan;
    s2_calc.is_inf   = s1_q.is_inf;
    // Exact cancellation gives -0 only when rounding toward -inf.
    s2_calc.sign     = (s1_q.op_sub && sum == 28'd0) ? (s1_q.rm == 2'b01) : s1_q.sign_l;
  end

  // ---------------- pipeline control ----------------
  always_comb begin
    s2_load    = ~s2_valid_q | bus.out_ready;
    in_ready   = ~s1_valid_q | s2_load;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = s2_calc;
    end
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_d = s1_calc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset as well because the output bundle must read zero in reset.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = s2_valid_q;
  assign bus.rm           = s2_q.rm;
  assign bus.is_nan       = s2_q.is_nan;
  assign bus.is_inf       = s2_q.is_inf;
  assign bus.inf_nan_frac = s2_q.is_nan ? 23'h400000 : 23'h000000;
  assign bus.sign         = s2_q.sign;
  assign bus.temp_exp     = s2_q.temp_exp;
  assign bus.cal_frac     = s2_q.cal_frac;

endmodule

// File: tb/tb_fadd_align.sv
// Scoreboard bench for fadd_align: directed cases, backpressure, reset flush and random traffic
// checked against an arithmetic reference model.
module tb_fadd_align;

  typedef struct packed {
    logic [1:0]  rm;
    logic        is_nan;
    logic        is_inf;
    logic [22:0] inf_nan_frac;
    logic        sign;
    logic [7:0]  temp_exp;
    logic [27:0] cal_frac;
  } res_t;

`ifdef FADD_ALIGN_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_mode = 1;  // 0: hold off, 1: always ready, 2: random
  res_t sb[$];
  int   pop_cyc[$];

  fadd_align_if bus ();
  fadd_align dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.rm           = bus.rm;
    r.is_nan       = bus.is_nan;
    r.is_inf       = bus.is_inf;
    r.inf_nan_frac = bus.inf_nan_frac;
    r.sign         = bus.sign;
    r.temp_exp     = bus.temp_exp;
    r.cal_frac     = bus.cal_frac;
    return r;
  endfunction

  function automatic res_t mk(input logic [1:0] rm, input logic nan, input logic inf,
                              input logic sgn, input logic [7:0] e, input logic [27:0] cal);
    res_t r;
    r.rm           = rm;
    r.is_nan       = nan;
    r.is_inf       = inf;
    r.inf_nan_frac = nan ? 23'h400000 : 23'h0;
    r.sign         = sgn;
    r.temp_exp     = e;
    r.cal_frac     = cal;
    return r;
  endfunction

  // Reference: significands as integers, denormals at exponent 1, sticky = nonzero remainder.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [1:0] rm);
    res_t   r;
    int     ea, eb, fa, fb, el, es, fl, fs, eff_l, eff_s, d;
    bit     sb_eff, is_sub, a_big, sgn_l, a_nan, b_nan, a_inf, b_inf;
    longint sig_l, sig_s, lg, sm, res;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = int'(a[22:0]);  fb = int'(b[22:0]);
    sb_eff = b[31] ^ (SUB_EN & s);
    is_sub = a[31] ^ sb_eff;
    a_big  = (ea > eb) || (ea == eb && fa >= fb);
    el = a_big ? ea : eb;  es = a_big ? eb : ea;
    fl = a_big ? fa : fb;  fs = a_big ? fb : fa;
    sgn_l = a_big ? a[31] : sb_eff;
    sig_l = longint'(fl) + ((el != 0) ? longint'(8388608) : longint'(0));
    sig_s = longint'(fs) + ((es != 0) ? longint'(8388608) : longint'(0));
    eff_l = (el == 0) ? 1 : el;
    eff_s = (es == 0) ? 1 : es;
    d  = eff_l - eff_s;
    lg = sig_l * 8;
    sm = sig_s * 8;
    if (d >= 26)                                sm = (sig_s != 0) ? 1 : 0;
    else if (sm % (longint'(1) << d) != 0)      sm = (sm >> d) | 1;
    else                                        sm = sm >> d;
    res = is_sub ? lg - sm : lg + sm;
    a_nan = (ea == 255) && (fa != 0);  b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0);  b_inf = (eb == 255) && (fb == 0);
    r.rm           = rm;
    r.is_nan       = a_nan | b_nan | (a_inf & b_inf & is_sub);
    r.is_inf       = a_inf | b_inf;
    r.inf_nan_frac = r.is_nan ? 23'h400000 : 23'h0;
    r.sign         = (is_sub && res == 0) ? (rm == 2'b01) : sgn_l;
    r.temp_exp     = 8'(el);
    r.cal_frac     = 28'(res);
    return r;
  endfunction

  function automatic logic [31:0] rand_fp(input int near_exp, input bit use_near);
    int          k, e;
    logic [22:0] f;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    if (k <= 5) begin
      e = use_near ? near_exp + $urandom_range(0, 30) - 15 : $urandom_range(1, 254);
      if (e < 1)   e = 1;
      if (e > 254) e = 254;
    end else if (k == 6) begin
      e = 0;
      if ($urandom_range(0, 1) == 0) f = 23'd0;
    end else if (k == 7) begin
      e = 255; f = 23'd0;
    end else if (k == 8) begin
      e = 255; if (f == 23'd0) f = 23'd1;
    end else begin
      return $urandom;
    end
    return {1'($urandom), 8'(e), f};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [1:0] rm);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.rm_in    = rm;
  endtask

  task automatic wait_accept(input res_t e);
    int n = 0;
    bit ok = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1) begin
      n++;
      if (n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: in_ready stuck at %b, want 1", bus.in_ready);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (ok) sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [1:0] rm, input res_t e);
    drive(a, b, s, rm);
    wait_accept(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer is compared against the oldest expected result.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got %h, want no output", dut_res());
      end else begin
        e = sb.pop_front();
        check("result", dut_res(), e);
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] ra, rb;
    int          n0;
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.rm_in = 2'b00;

    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_bundle", dut_res(), 64'd0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    #1 check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed cases with hand-derived results
    send(32'h3F800000, 32'h3F800000, 1'b0, 2'b00, mk(2'b00, 0, 0, 0, 8'h7F, 28'h8000000));
    send(32'h3F800000, 32'hBF800000, 1'b0, 2'b00, mk(2'b00, 0, 0, 0, 8'h7F, 28'h0000000));
    send(32'h3F800000, 32'hBF800000, 1'b0, 2'b01, mk(2'b01, 0, 0, 1, 8'h7F, 28'h0000000));
    send(32'h4B800000, 32'h3A800000, 1'b0, 2'b00, mk(2'b00, 0, 0, 0, 8'h97, 28'h4000001));
    send(32'h7F800000, 32'hFF800000, 1'b0, 2'b00, mk(2'b00, 1, 1, 0, 8'hFF, 28'h0000000));
    send(32'h7F800000, 32'h3F800000, 1'b0, 2'b10, mk(2'b10, 0, 1, 0, 8'hFF, 28'h4000001));
    send(32'h7FC00001, 32'h3F800000, 1'b0, 2'b11, mk(2'b11, 1, 0, 0, 8'hFF, 28'h6000009));
    send(32'h3F800000, 32'h3F800000, 1'b1, 2'b00,
         SUB_EN ? mk(2'b00, 0, 0, 0, 8'h7F, 28'h0000000) : mk(2'b00, 0, 0, 0, 8'h7F, 28'h8000000));
    wait_drain();

    // Backpressure: two accepted, then stall with outputs frozen, then in-order release
    ready_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 2'b10, mk(2'b10, 0, 0, 0, 8'h7F, 28'h8000000));
    send(32'h4B800000, 32'h3A800000, 1'b0, 2'b00, mk(2'b00, 0, 0, 0, 8'h97, 28'h4000001));
    drive(32'h3F800000, 32'hBF800000, 1'b0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold", dut_res(), sb[0]);
    end
    n0 = pop_cyc.size();
    ready_mode = 1;
    wait_accept(mk(2'b01, 0, 0, 1, 8'h7F, 28'h0000000));
    send(32'h7F800000, 32'h3F800000, 1'b0, 2'b00, mk(2'b00, 0, 1, 0, 8'hFF, 28'h4000001));
    wait_drain();
    if (pop_cyc.size() < n0 + 4) begin
      n_cmp++; n_bad++;
      $display("FAIL bp_release_count: got %0d results, want 4", pop_cyc.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++)
        check("bp_one_per_cycle", 64'(pop_cyc[n0+i+1] - pop_cyc[n0+i]), 64'd1);
    end

    // Random traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      logic       s;
      logic [1:0] rm;
      ra = rand_fp(0, 1'b0);
      rb = rand_fp(int'(ra[30:23]), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) rb = {~ra[31], ra[30:0]};
      s  = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      send(ra, rb, s, rm, model(ra, rb, s, rm));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    ready_mode = 1;
    wait_drain();

    // Reset with both stages full discards in-flight data
    ready_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 2'b11, mk(2'b11, 0, 0, 0, 8'h7F, 28'h8000000));
    send(32'h4B800000, 32'h3A800000, 1'b0, 2'b10, mk(2'b10, 0, 0, 0, 8'h97, 28'h4000001));
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_bundle", dut_res(), 64'd0);
    sb.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    ready_mode = 1;
    repeat (6) @(negedge clk);
    check("rst_no_stale", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fadd_align.md
# fadd_align

Front-end stage of the pipelined single-precision adder; it produces exactly the fields the normalize/round stage consumes. Two IEEE-754 binary32 operands are unpacked, special cases classified, operands swapped by magnitude, the smaller significand right-aligned with sticky, and added or subtracted. It is a 2-stage valid/ready pipeline whose output bundle connects directly to the normalization stage inputs.

## Interface
- No parameters; all widths fixed for binary32.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage 1 can accept this cycle.
- a, b  in  32  binary32 operands.
- sub  in  1  compute a−b instead of a+b (see Configuration).
- rm_in  in  2  rounding mode: 00 nearest-even, 01 toward −inf, 10 toward +inf, 11 toward zero.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts.
- rm  out  2  rounding mode carried with the data.
- is_nan, is_inf  out  1  special-case flags.
- inf_nan_frac  out  23  fraction for the special result.
- sign  out  1  result sign.
- temp_exp  out  8  exponent of the larger-magnitude operand.
- cal_frac  out  28  raw significand result: bit 27 carry, 26 hidden, 25:3 fraction, 2:0 guard/round/sticky.

## Operation
- Stage 1, registered on acceptance:
  - eb_sign = b[31] ^ sub_eff; op_sub = a[31] ^ eb_sign.
  - Swap if a[30:0] < b[30:0]; large/small take magnitude plus effective sign.
  - hidden = |exp. large24 = {hidden_l, frac_l}; small24 likewise.
  - shift = exp_l − exp_s, minus 1 when exp_l≠0 and exp_s==0.
  - shift ≥ 26: small27 = {26'b0, |small24}. Otherwise small27 = ({small24,3'b0} >> shift) with bit 0 ORed with every shifted-out bit.
  - Register large27 = {large24,3'b0}, small27, exp_l, sign_l, op_sub, rm_in, special flags.
- Special flags:
  - is_nan = a NaN | b NaN | (both inf & op_sub).
  - is_inf = a inf | b inf.
  - inf_nan_frac = is_nan ? 23'h400000 : 23'h0.
- Stage 2, registered:
  - cal_frac = {1'b0,large27} ± {1'b0,small27}.
  - sign = sign_l, except when op_sub and the difference is 0: sign = (rm==01).
  - temp_exp = exp_l.
- Swapping by magnitude guarantees the subtraction never goes negative.

## Timing
- Latency 2 cycles from acceptance to out_valid; throughput 1 per cycle.
- A transfer occurs on valid&ready at each interface.
- Stage 2 loads when empty or when out_ready=1.
- Stage 1 advances when stage 2 loads. in_ready = ~s1_valid | s2_load; combinational from out_ready.
- While out_valid=1 and out_ready=0, all outputs hold stable.
- Both stages full with out_ready=0: in_ready=0, no data lost or reordered.
- Simultaneous accept and drain in the same cycle sustains full throughput.
- Reset: both valid bits and all output registers clear to 0 immediately: out_valid=0, cal_frac=0, temp_exp=0, sign=0, flags=0, rm=00. in_ready=1 once reset deasserts. In-flight data is discarded.

## Configuration
- FADD_ALIGN_SUB_EN defined: sub_eff = sub, so the block performs add or subtract.
- FADD_ALIGN_SUB_EN undefined: sub is ignored (sub_eff = 0), making the block add-only. The port remains for a uniform interface.

## Test plan
- 1.0 + 1.0 (a=b=3F800000, rm=00): two cycles later out_valid=1, temp_exp=7F, cal_frac=28'h8000000, sign=0, flags 0.
- a=3F800000, b=BF800000, rm=00: cal_frac=0, sign=0. With rm=01: sign=1.
- Sticky path, a=4B800000, b=3A800000 (shift 34): temp_exp=97, cal_frac=28'h4000001.
- Special cases:
  - a=7F800000, b=FF800000: is_nan=1, inf_nan_frac=400000.
  - a=7F800000, b=3F800000: is_inf=1, is_nan=0.
  - a=7FC00001 (NaN): is_nan=1.
- Backpressure: 4 back-to-back ops with out_ready=0 for 5 cycles → in_ready=0 after 2 accepted, outputs frozen; on release, results emerge in order, one per cycle.
- Assert rst with both stages full → out_valid=0 the same cycle, no stale output after deassertion. With the macro undefined, sub=1 on 1.0,1.0 gives cal_frac=28'h8000000.
